mem_bus_unit: RTL and testbench

- Memory-side partner of the CPU control sequencer.
- Translates the 16-bit virtual address into a physical address through a 16-entry page table, and drives CurrPTE back to the sequencer combinationally for its permission checks.
- Runs level-held read/write requests from the sequencer as external bus cycles, and answers each completed access with MemOK.
- Adds a write/read permission gate of its own, a not-present check and a bus timeout.

---
 rtl/mem_bus_unit.sv | 182 ++++++++++++++++++
 tb/tb_mem_bus_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_unit
// Purpose  : Page-table translation, permission gate and external bus cycles
//            for the CPU control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_unit #(
   parameter int TIMEOUT = 64,
   parameter int TW      = 7
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [15:0] VAddr,
   input  logic [15:0] WData,
   input  logic        MemRRq,
   input  logic        MemWRq,
   input  logic        MemAck,
   input  logic        PLevel,
   output logic [15:0] CurrPTE,
   output logic        MemOK,
   output logic [15:0] RData,
   output logic        MemFault,
   output logic [19:0] BusAddr,
   output logic [15:0] BusWData,
   output logic        BusRd,
   output logic        BusWr,
   input  logic [15:0] BusRData,
   input  logic        BusReady,
   input  logic        PteWe,
   input  logic [3:0]  PteIdx,
   input  logic [15:0] PteData
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RD        = 3'd1,
      S_WR        = 3'd2,
      S_DONE      = 3'd3,
      S_WAIT_DROP = 3'd4
   } state_t;

   localparam logic [TW-1:0] C_TIMEOUT = TW'(TIMEOUT);

   state_t        state_q, state_d;
   logic [15:0]   pt_q [16];
   logic [15:0]   pt_d [16];
   logic [TW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          mem_ok_q, mem_ok_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          fault_q, fault_d;
   logic [19:0]   bus_addr_q, bus_addr_d;
   logic [15:0]   bus_wdata_q, bus_wdata_d;
   logic          bus_rd_q, bus_rd_d;
   logic          bus_wr_q, bus_wr_d;

   logic          req, allowed;
   logic [15:0]   curr_pte;

   assign curr_pte = pt_q[VAddr[15:12]];
   assign req      = MemRRq | MemWRq;
   assign cnt_inc  = cnt_q + 1'b1;

   // A simultaneous read and write request is handled as a write.
   assign allowed  = curr_pte[11] &
                     (~PLevel | (MemWRq ? curr_pte[14] : (curr_pte[15] | curr_pte[13])));

   always_comb begin
      state_d     = state_q;
      pt_d        = pt_q;
      cnt_d       = cnt_q;
      mem_ok_d    = mem_ok_q;
      rdata_d     = rdata_q;
      fault_d     = 1'b0;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_rd_d    = bus_rd_q;
      bus_wr_d    = bus_wr_q;

      if (PteWe) begin
         pt_d[PteIdx] = PteData;
      end

      case (state_q)
         S_IDLE: begin
            if (req) begin
               bus_addr_d  = {curr_pte[7:0], VAddr[11:0]};
               bus_wdata_d = WData;
               if (allowed) begin
                  cnt_d = '0;
                  if (MemWRq) begin
                     state_d  = S_WR;
                     bus_wr_d = 1'b1;
                  end else begin
                     state_d  = S_RD;
                     bus_rd_d = 1'b1;
                  end
               end else begin
                  fault_d = 1'b1;
                  state_d = S_WAIT_DROP;
               end
            end
         end
         S_RD, S_WR: begin
            if (BusReady) begin
               bus_rd_d = 1'b0;
               bus_wr_d = 1'b0;
               if (state_q == S_RD) begin
                  rdata_d = BusRData;
               end
               // A request withdrawn mid-transfer discards the result.
               if (req) begin
                  state_d  = S_DONE;
                  mem_ok_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (cnt_inc == C_TIMEOUT) begin
               bus_rd_d = 1'b0;
               bus_wr_d = 1'b0;
               fault_d  = 1'b1;
               state_d  = S_WAIT_DROP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_DONE: begin
            if (MemAck || !req) begin
               mem_ok_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         S_WAIT_DROP: begin
            if (!req) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= S_IDLE;
         for (int i = 0; i < 16; i++) begin
            pt_q[i] <= 16'h1800 | 16'(i);
         end
         cnt_q       <= '0;
         mem_ok_q    <= 1'b0;
         rdata_q     <= '0;
         fault_q     <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_rd_q    <= 1'b0;
         bus_wr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pt_q        <= pt_d;
         cnt_q       <= cnt_d;
         mem_ok_q    <= mem_ok_d;
         rdata_q     <= rdata_d;
         fault_q     <= fault_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_rd_q    <= bus_rd_d;
         bus_wr_q    <= bus_wr_d;
      end
   end

   assign CurrPTE  = curr_pte;
   assign MemOK    = mem_ok_q;
   assign RData    = rdata_q;
   assign MemFault = fault_q;
   assign BusAddr  = bus_addr_q;
   assign BusWData = bus_wdata_q;
   assign BusRd    = bus_rd_q;
   assign BusWr    = bus_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_unit
// Purpose  : Scoreboard bench for mem_bus_unit: directed accesses, faults,
//            bus timeout and mid-transfer reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_unit;

   localparam int K_RD    = 0;
   localparam int K_WR    = 1;
   localparam int K_OK    = 2;
   localparam int K_FAULT = 3;

   typedef struct {
      int          kind;
      logic [19:0] addr;
      logic [15:0] data;
      logic        chk_data;
   } exp_t;

   logic        clk = 1'b0;
   logic        Rst;
   logic [15:0] VAddr, WData, BusRData, PteData;
   logic        MemRRq, MemWRq, MemAck, PLevel, BusReady, PteWe;
   logic [3:0]  PteIdx;
   logic [15:0] CurrPTE, RData, BusWData;
   logic        MemOK, MemFault, BusRd, BusWr;
   logic [19:0] BusAddr;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   logic p_rd = 1'b0, p_wr = 1'b0, p_ok = 1'b0, p_f = 1'b0;

   mem_bus_unit #(.TIMEOUT(64), .TW(7)) dut (
      .Clk(clk), .Rst(Rst), .VAddr(VAddr), .WData(WData),
      .MemRRq(MemRRq), .MemWRq(MemWRq), .MemAck(MemAck), .PLevel(PLevel),
      .CurrPTE(CurrPTE), .MemOK(MemOK), .RData(RData), .MemFault(MemFault),
      .BusAddr(BusAddr), .BusWData(BusWData), .BusRd(BusRd), .BusWr(BusWr),
      .BusRData(BusRData), .BusReady(BusReady),
      .PteWe(PteWe), .PteIdx(PteIdx), .PteData(PteData)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push(input int kind, input logic [19:0] addr, input logic [15:0] data,
                       input logic chk_data);
      exp_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.chk_data = chk_data;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input int kind, input logic [19:0] addr, input logic [15:0] data);
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event actual=kind%0d required=none", kind);
      end else begin
         e = sb_q.pop_front();
         check("event_kind", 32'(kind), 32'(e.kind));
         if (kind == K_RD || kind == K_WR) check("bus_addr", 32'(addr), 32'(e.addr));
         if (kind == K_WR) check("bus_wdata", 32'(data), 32'(e.data));
         if (kind == K_OK && e.chk_data) check("rdata", 32'(data), 32'(e.data));
      end
   endtask

   // Monitor: pops the scoreboard on each rising output event.
   always @(negedge clk) begin
      if (BusRd === 1'b1 && !p_rd) sb_pop(K_RD, BusAddr, 16'h0);
      if (BusWr === 1'b1 && !p_wr) sb_pop(K_WR, BusAddr, BusWData);
      if (MemOK === 1'b1 && !p_ok) sb_pop(K_OK, 20'h0, RData);
      if (MemFault === 1'b1 && !p_f) sb_pop(K_FAULT, 20'h0, 16'h0);
      if (p_f) check("fault_width", 32'(MemFault), 32'd0);
      p_rd <= (BusRd === 1'b1);
      p_wr <= (BusWr === 1'b1);
      p_ok <= (MemOK === 1'b1);
      p_f  <= (MemFault === 1'b1);
   end

   task automatic run_access(input logic rrq, input logic wrq, input logic pl,
                             input logic [15:0] va, input logic [15:0] wd,
                             input logic [15:0] resp, input int dly, input int hold);
      int n;
      @(negedge clk);
      PLevel = pl; VAddr = va; WData = wd; MemRRq = rrq; MemWRq = wrq;
      @(negedge clk);
      n = 0;
      while (!(BusRd === 1'b1 || BusWr === 1'b1 || MemFault === 1'b1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL access_start actual=no_response required=strobe_or_fault");
      end else if (MemFault === 1'b1) begin
         repeat (hold) @(negedge clk);
      end else begin
         repeat (dly) @(negedge clk);
         BusReady = 1'b1; BusRData = resp;
         @(negedge clk);
         BusReady = 1'b0; BusRData = 16'h0;
         n = 0;
         while (MemOK !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (n >= 50) begin
            checks++; errors++;
            $display("FAIL memok_wait actual=MemOK_low required=MemOK_high");
         end else begin
            repeat (hold) begin
               @(negedge clk);
               check("memok_held", 32'(MemOK), 32'd1);
            end
            MemAck = 1'b1; MemRRq = 1'b0; MemWRq = 1'b0;
            @(negedge clk);
            MemAck = 1'b0;
            check("memok_clear", 32'(MemOK), 32'd0);
         end
      end
      MemRRq = 1'b0; MemWRq = 1'b0;
      @(negedge clk);
   endtask

   task automatic write_pte(input logic [3:0] idx, input logic [15:0] val);
      @(negedge clk);
      PteWe = 1'b1; PteIdx = idx; PteData = val;
      @(negedge clk);
      PteWe = 1'b0;
   endtask

   initial begin
      int n;
      Rst = 1'b1; VAddr = 16'h0; WData = 16'h0; MemRRq = 1'b0; MemWRq = 1'b0;
      MemAck = 1'b0; PLevel = 1'b0; BusRData = 16'h0; BusReady = 1'b0;
      PteWe = 1'b0; PteIdx = 4'h0; PteData = 16'h0;
      repeat (3) @(negedge clk);
      Rst = 1'b0;

      // Reset state
      check("rst_memok", 32'(MemOK), 32'd0);
      check("rst_fault", 32'(MemFault), 32'd0);
      check("rst_busrd", 32'(BusRd), 32'd0);
      check("rst_buswr", 32'(BusWr), 32'd0);
      check("rst_rdata", 32'(RData), 32'h0);
      check("rst_busaddr", 32'(BusAddr), 32'h0);
      check("rst_buswdata", 32'(BusWData), 32'h0);
      check("rst_pte0", 32'(CurrPTE), 32'h1800);
      VAddr = 16'hF000; #1;
      check("rst_pte15", 32'(CurrPTE), 32'h180F);

      // 1: privileged read, identity map
      VAddr = 16'h3004; #1;
      check("pte3", 32'(CurrPTE), 32'h1803);
      push(K_RD, 20'h03004, 16'h0, 1'b0);
      push(K_OK, 20'h0, 16'hBEEF, 1'b1);
      run_access(1'b1, 1'b0, 1'b0, 16'h3004, 16'h0, 16'hBEEF, 0, 3);

      // 2: PTE write visible next cycle, then unprivileged write
      @(negedge clk);
      VAddr = 16'h2010; PteWe = 1'b1; PteIdx = 4'h2; PteData = 16'h4805; #1;
      check("pte_old", 32'(CurrPTE), 32'h1802);
      @(negedge clk);
      PteWe = 1'b0;
      check("pte_new", 32'(CurrPTE), 32'h4805);
      push(K_WR, 20'h05010, 16'h1234, 1'b0);
      push(K_OK, 20'h0, 16'h0, 1'b0);
      run_access(1'b0, 1'b1, 1'b1, 16'h2010, 16'h1234, 16'h0, 2, 1);

      // 3: unprivileged write to a page without user-write
      push(K_FAULT, 20'h0, 16'h0, 1'b0);
      run_access(1'b0, 1'b1, 1'b1, 16'h0100, 16'hAAAA, 16'h0, 0, 4);

      // 4: not-present page, privileged read
      write_pte(4'h7, 16'h0007);
      push(K_FAULT, 20'h0, 16'h0, 1'b0);
      run_access(1'b1, 1'b0, 1'b0, 16'h7000, 16'h0, 16'h0, 0, 2);

      // Unprivileged read denied with only priv-exec set
      push(K_FAULT, 20'h0, 16'h0, 1'b0);
      run_access(1'b1, 1'b0, 1'b1, 16'h3000, 16'h0, 16'h0, 0, 1);

      // Unprivileged read allowed through user-exec
      write_pte(4'h5, 16'h2806);
      push(K_RD, 20'h06ABC, 16'h0, 1'b0);
      push(K_OK, 20'h0, 16'h5A5A, 1'b1);
      run_access(1'b1, 1'b0, 1'b1, 16'h5ABC, 16'h0, 16'h5A5A, 1, 1);

      // Both requests high is a write
      push(K_WR, 20'h01008, 16'hC3C3, 1'b0);
      push(K_OK, 20'h0, 16'h0, 1'b0);
      run_access(1'b1, 1'b1, 1'b0, 16'h1008, 16'hC3C3, 16'h0, 0, 1);

      // 5: bus timeout
      push(K_RD, 20'h0A000, 16'h0, 1'b0);
      push(K_FAULT, 20'h0, 16'h0, 1'b0);
      @(negedge clk);
      PLevel = 1'b0; VAddr = 16'hA000; MemRRq = 1'b1;
      n = 0;
      while (BusRd !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (BusRd === 1'b1 && n < 200) begin @(negedge clk); n++; end
      check("timeout_strobe_len", 32'(n), 32'd64);
      check("timeout_fault", 32'(MemFault), 32'd1);
      repeat (3) @(negedge clk);
      MemRRq = 1'b0;
      @(negedge clk);

      // 6: reset mid-write
      push(K_WR, 20'h0C000, 16'h7777, 1'b0);
      PLevel = 1'b0; VAddr = 16'hC000; WData = 16'h7777; MemWRq = 1'b1;
      n = 0;
      while (BusWr !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      Rst = 1'b1;
      @(negedge clk);
      check("rst_mid_buswr", 32'(BusWr), 32'd0);
      check("rst_mid_memok", 32'(MemOK), 32'd0);
      check("rst_mid_busaddr", 32'(BusAddr), 32'h0);
      Rst = 1'b0; MemWRq = 1'b0;
      VAddr = 16'h2010; #1;
      check("rst_pte_reinit", 32'(CurrPTE), 32'h1802);
      push(K_RD, 20'h02010, 16'h0, 1'b0);
      push(K_OK, 20'h0, 16'h0F0F, 1'b1);
      run_access(1'b1, 1'b0, 1'b0, 16'h2010, 16'h0, 16'h0F0F, 0, 1);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
